// File: rtl/demux_4_op.sv
// demux_4_op: routes one input word stream into four independent output FIFOs
//    clk       : clock, all state updates on rising edge
//    rst_n     : asynchronous active-low reset, clears pointers, counts and storage
//    in_valid  : producer offers in_data
//    in_ready  : decoded channel has room (depends only on in_sel and counts)
//    in_data   : word to route
//    in_sel    : channel select (00->0, 10->1, 01->2, 11->3)
//    out_valid : bit k set while channel k holds data
//    out_ready : bit k pops the head word of channel k
//    out_data  : channel k head word on [WIDTH*k +: WIDTH]
//    busy      : any channel non-empty
module demux_4_op #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [1:0]         in_sel,
   output logic [3:0]         out_valid,
   input  logic [3:0]         out_ready,
   output logic [4*WIDTH-1:0] out_data,
   output logic               busy
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   logic [WIDTH-1:0] mem_q [4][DEPTH];
   logic [AW-1:0] rptr_q [4];
   logic [AW-1:0] rptr_d [4];
   logic [AW-1:0] wptr_q [4];
   logic [AW-1:0] wptr_d [4];
   logic [AW:0] cnt_q [4];
   logic [AW:0] cnt_d [4];
   logic [1:0] ch;
   logic [3:0] push;
   logic [3:0] pop;
   // select bits are swapped relative to the channel number
   assign ch = {in_sel[0], in_sel[1]};
   // a pop in the same cycle does not free space for a push: in_ready sees registered count only
   assign in_ready = cnt_q[ch] != FULL;
   assign busy = |out_valid;
   always_comb begin
      push = '0;
      pop = '0;
      out_valid = '0;
      out_data = '0;
      for (int k = 0; k < 4; k++) begin
         out_valid[k] = cnt_q[k] != '0;
         out_data[WIDTH*k +: WIDTH] = mem_q[k][rptr_q[k]];
         push[k] = in_valid && in_ready && (ch == 2'(k));
         pop[k] = out_valid[k] && out_ready[k];
         wptr_d[k] = push[k] ? wptr_q[k] + 1'b1 : wptr_q[k];
         rptr_d[k] = pop[k] ? rptr_q[k] + 1'b1 : rptr_q[k];
         cnt_d[k] = (push[k] && !pop[k]) ? cnt_q[k] + 1'b1 :
                    (pop[k] && !push[k]) ? cnt_q[k] - 1'b1 : cnt_q[k];
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) begin
            rptr_q[k] <= '0;
            wptr_q[k] <= '0;
            cnt_q[k] <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[k][i] <= '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (push[k]) mem_q[k][wptr_q[k]] <= in_data;
            rptr_q[k] <= rptr_d[k];
            wptr_q[k] <= wptr_d[k];
            cnt_q[k] <= cnt_d[k];
         end
      end
   end
endmodule

// File: doc/demux_4_op.md
DEMUX_4_OP -- requirements
Module: demux_4_op

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width of the input and of each output channel.
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the entries per output channel FIFO (power of two, >= 2).
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit, meaning the producer offers a word.
REQ-007 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts the offered word this cycle.
REQ-008 The block SHALL have port in_data, input, WIDTH bits, the word to route.
REQ-009 The block SHALL have port in_sel, input, 2 bits, the destination channel select.
REQ-010 The block SHALL have port out_valid, output, 4 bits, where bit k means channel k holds data.
REQ-011 The block SHALL have port out_ready, input, 4 bits, where bit k means the consumer of channel k takes its head word.
REQ-012 The block SHALL have port out_data, output, 4*WIDTH bits, with channel k on bits [WIDTH*k+WIDTH-1 : WIDTH*k].
REQ-013 The block SHALL have port busy, output, 1 bit, meaning any channel FIFO is non-empty.

Function
REQ-014 in_sel decode SHALL be 2'b00 -> channel 0, 2'b10 -> channel 1, 2'b01 -> channel 2, 2'b11 -> channel 3, matching the operand-mux select encoding.
REQ-015 Each channel SHALL own an independent DEPTH-entry FIFO with a read pointer, a write pointer and an occupancy count of 0..DEPTH.
REQ-016 in_ready SHALL be 1 iff the channel decoded from the current in_sel has count < DEPTH, combinational from in_sel and registered counts only, with no path from out_ready or in_valid.
REQ-017 A push SHALL occur when in_valid and in_ready are both 1; in_data is written at the write pointer of the decoded channel, and that write pointer increments modulo DEPTH.
REQ-018 The latency from push to visibility SHALL be 1 cycle: out_valid[k] rises on the clock edge that performs the first push into empty channel k.
REQ-019 out_valid[k] SHALL equal (count_k != 0), and out_data for channel k SHALL always present the entry at read pointer k.
REQ-020 A pop SHALL occur on channel k when out_valid[k] and out_ready[k] are both 1; read pointer k increments modulo DEPTH.
REQ-021 A simultaneous push and pop on the same channel SHALL leave count unchanged, advance both pointers, and preserve FIFO order.
REQ-022 When a channel is full (count = DEPTH), a pop in the same cycle SHALL NOT allow a push that cycle; in_ready rises the following cycle.
REQ-023 Pops on different channels SHALL proceed in the same cycle, independently of each other and of the push.
REQ-024 A full channel SHALL NOT block pushes to other channels; in_ready follows in_sel each cycle.
REQ-025 Pointers SHALL wrap from DEPTH-1 to 0 without data loss or duplication.
REQ-026 Ordering SHALL be guaranteed only within a channel, never across channels.
REQ-027 busy SHALL be the OR of all out_valid bits.
REQ-028 out_ready[k] asserted while channel k is empty SHALL have no effect.
REQ-029 in_data and in_sel SHALL be don't-care when in_valid = 0.

Reset
REQ-030 While rst_n = 0, all pointers and counts SHALL be 0, all storage SHALL be 0, out_valid SHALL be 4'b0000, out_data SHALL be all zero, and busy SHALL be 0.
REQ-031 in_ready SHALL be 1 during reset.
REQ-032 Reset asserted mid-operation SHALL discard all buffered words immediately and asynchronously, without waiting for a clock edge.
REQ-033 No push or pop SHALL occur on the first rising edge at which rst_n = 0.

Verification
REQ-034 The bench SHALL drive a single word: in_sel=2'b10, in_data=32'hDEADBEEF, one cycle -> next cycle out_valid=4'b0010, channel 1 data=32'hDEADBEEF; then out_ready[1]=1 -> out_valid=0, busy=0.
REQ-035 The bench SHALL check the select encoding: push 32'h1, 32'h2, 32'h3, 32'h4 with sel 00, 10, 01, 11 -> out_valid=4'b1111, channel k data=k+1.
REQ-036 The bench SHALL check a full channel: 3 pushes to channel 0 with out_ready=0 -> 2 accepted, in_ready=0 on the third; with in_sel=2'b11, in_ready=1.
REQ-037 The bench SHALL check simultaneous push and pop at count=1 on channel 2 -> count stays 1, outputs appear in push order, and after 5 words the pointer wrap shows no loss.
REQ-038 The bench SHALL check full-plus-pop: channel 3 full, out_ready[3]=1 with in_valid=1 -> no push that cycle, in_ready=1 the next cycle, accepted word appears last.
REQ-039 The bench SHALL check reset mid-operation: load 2 words into every channel, pulse rst_n low between clock edges -> out_valid=0 and out_data=0 immediately, busy=0, and the first push after release has latency 1.
